ca_code_gen: RTL

Generates the GPS L1 C/A Gold-code chip for all 36 supported PRNs in parallel, advanced by a programmable chip-rate NCO. It sits directly upstream of every satellite channel. Its `ca_seq` bus is fanned out to all channels, and each channel picks its own PRN bit with its `ca_sel` index. The block also marks code epochs (1 ms) and navigation-bit epochs (20 ms) for the message-injection logic.

---
 rtl/gps_ca_pkg.sv | 37 +++
 rtl/ca_chip_nco.sv | 29 ++
 rtl/ca_code_gen.sv | 116 +++++++++++
 3 files changed

// File: rtl/gps_ca_pkg.sv
// Shared constants for the GPS L1 C/A code generator: code geometry, LFSR seed,
// G2 phase-select taps and the chip-rate NCO increment helper.
package gps_ca_pkg;

  localparam int unsigned CA_LEN     = 1023;
  localparam int unsigned NAV_EPOCHS = 20;
  localparam int unsigned LFSR_W     = 10;
  localparam int unsigned MAX_SV     = 36;
  localparam int unsigned TAP_W      = 4;

  localparam logic [LFSR_W-1:0] LFSR_INIT = 10'h3FF;

  // 1-based G2 stage indices combined to form each PRN's delayed G2 output
  typedef struct packed {
    logic [TAP_W-1:0] tap_a;
    logic [TAP_W-1:0] tap_b;
  } g2_taps_t;

  localparam g2_taps_t G2_TAPS [MAX_SV] = '{
    '{4'd2, 4'd6},  '{4'd3, 4'd7},  '{4'd4, 4'd8},  '{4'd5, 4'd9},
    '{4'd1, 4'd9},  '{4'd2, 4'd10}, '{4'd1, 4'd8},  '{4'd2, 4'd9},
    '{4'd3, 4'd10}, '{4'd2, 4'd3},  '{4'd3, 4'd4},  '{4'd5, 4'd6},
    '{4'd6, 4'd7},  '{4'd7, 4'd8},  '{4'd8, 4'd9},  '{4'd9, 4'd10},
    '{4'd1, 4'd4},  '{4'd2, 4'd5},  '{4'd3, 4'd6},  '{4'd4, 4'd7},
    '{4'd5, 4'd8},  '{4'd6, 4'd9},  '{4'd1, 4'd3},  '{4'd4, 4'd6},
    '{4'd5, 4'd7},  '{4'd6, 4'd8},  '{4'd7, 4'd9},  '{4'd8, 4'd10},
    '{4'd1, 4'd6},  '{4'd2, 4'd7},  '{4'd3, 4'd8},  '{4'd4, 4'd9},
    '{4'd5, 4'd10}, '{4'd4, 4'd10}, '{4'd1, 4'd7},  '{4'd2, 4'd8}
  };

  // Nominal NCO increment: 1.023 MHz * 2^phase_w / f_clk (valid for phase_w <= 42)
  function automatic logic [63:0] chip_nco_incr(input logic [63:0] f_clk_hz,
                                                input int unsigned phase_w);
    return (64'd1023000 << phase_w) / f_clk_hz;
  endfunction

endpackage

// File: rtl/ca_chip_nco.sv
// Chip-rate phase accumulator; the carry out of each accumulate is one chip advance.
module ca_chip_nco #(
  parameter int unsigned PHASE_W = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_load,
  input  logic [PHASE_W-1:0] i_freq,
  output logic               o_adv_c
);

  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W:0]   w_sum;

  assign w_sum   = {1'b0, r_phase} + {1'b0, i_freq};
  assign o_adv_c = i_enable & ~i_load & w_sum[PHASE_W];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase <= '0;
    end else if (i_load) begin
      r_phase <= '0;
    end else if (i_enable) begin
      r_phase <= w_sum[PHASE_W-1:0];
    end
  end

endmodule

// File: rtl/ca_code_gen.sv
// GPS L1 C/A Gold-code generator for all PRNs in parallel, with chip index,
// code-epoch and nav-bit-epoch strobes, advanced by a shared chip NCO.
module ca_code_gen
  import gps_ca_pkg::*;
#(
  parameter int unsigned NUM_SV  = 36,
  parameter int unsigned PHASE_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               load,
  input  logic [PHASE_W-1:0] chip_freq,
  output logic [NUM_SV-1:0]  ca_seq,
  output logic [9:0]         chip_idx,
  output logic               chip_stb,
  output logic               epoch,
  output logic               bit_epoch,
  output logic [4:0]         epoch_cnt
);

  localparam int unsigned IDX_W  = 10;
  localparam int unsigned ECNT_W = 5;
  localparam logic [IDX_W-1:0]  CHIP_LAST = IDX_W'(CA_LEN - 1);
  localparam logic [ECNT_W-1:0] ECNT_LAST = ECNT_W'(NAV_EPOCHS - 1);

  logic              w_adv;
  logic [LFSR_W-1:0] r_g1, r_g2, w_g1_nxt, w_g2_nxt;
  logic [IDX_W-1:0]  r_chip_idx, w_idx_nxt;
  logic [ECNT_W-1:0] r_epoch_cnt, w_ecnt_nxt;
  logic [NUM_SV-1:0] r_ca_seq, w_ca_nxt;
  logic              r_chip_stb, r_epoch, r_bit_epoch;
  logic              w_stb_nxt, w_ep_nxt, w_bep_nxt;

  ca_chip_nco #(.PHASE_W(PHASE_W)) u_nco (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_enable (enable),
    .i_load   (load),
    .i_freq   (chip_freq),
    .o_adv_c  (w_adv)
  );

  // Next LFSR/counter state; vector bit k holds LFSR stage k+1
  always_comb begin
    w_g1_nxt   = r_g1;
    w_g2_nxt   = r_g2;
    w_idx_nxt  = r_chip_idx;
    w_ecnt_nxt = r_epoch_cnt;
    w_stb_nxt  = 1'b0;
    w_ep_nxt   = 1'b0;
    w_bep_nxt  = 1'b0;
    if (load) begin
      w_g1_nxt   = LFSR_INIT;
      w_g2_nxt   = LFSR_INIT;
      w_idx_nxt  = '0;
      w_ecnt_nxt = '0;
    end else if (w_adv) begin
      w_stb_nxt = 1'b1;
      if (r_chip_idx == CHIP_LAST) begin
        // Forced reload keeps the code aligned to the epoch even after an upset
        w_g1_nxt  = LFSR_INIT;
        w_g2_nxt  = LFSR_INIT;
        w_idx_nxt = '0;
        w_ep_nxt  = 1'b1;
        if (r_epoch_cnt == ECNT_LAST) begin
          w_ecnt_nxt = '0;
          w_bep_nxt  = 1'b1;
        end else begin
          w_ecnt_nxt = r_epoch_cnt + ECNT_W'(1);
        end
      end else begin
        w_g1_nxt  = {r_g1[LFSR_W-2:0], r_g1[2] ^ r_g1[9]};
        w_g2_nxt  = {r_g2[LFSR_W-2:0],
                     r_g2[1] ^ r_g2[2] ^ r_g2[5] ^ r_g2[7] ^ r_g2[8] ^ r_g2[9]};
        w_idx_nxt = r_chip_idx + IDX_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_SV; i++) begin : g_prn
    localparam logic [TAP_W-1:0] TA = G2_TAPS[i].tap_a - 4'd1;
    localparam logic [TAP_W-1:0] TB = G2_TAPS[i].tap_b - 4'd1;
    assign w_ca_nxt[i] = w_g1_nxt[LFSR_W-1] ^ w_g2_nxt[TA] ^ w_g2_nxt[TB];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_g1        <= LFSR_INIT;
      r_g2        <= LFSR_INIT;
      r_chip_idx  <= '0;
      r_epoch_cnt <= '0;
      r_ca_seq    <= '1;
      r_chip_stb  <= 1'b0;
      r_epoch     <= 1'b0;
      r_bit_epoch <= 1'b0;
    end else begin
      r_g1        <= w_g1_nxt;
      r_g2        <= w_g2_nxt;
      r_chip_idx  <= w_idx_nxt;
      r_epoch_cnt <= w_ecnt_nxt;
      r_ca_seq    <= w_ca_nxt;
      r_chip_stb  <= w_stb_nxt;
      r_epoch     <= w_ep_nxt;
      r_bit_epoch <= w_bep_nxt;
    end
  end

  assign ca_seq    = r_ca_seq;
  assign chip_idx  = r_chip_idx;
  assign chip_stb  = r_chip_stb;
  assign epoch     = r_epoch;
  assign bit_epoch = r_bit_epoch;
  assign epoch_cnt = r_epoch_cnt;

endmodule
